dpram_wr_arbiter: RTL

- Write-side controller for the shared 4x4 dual-port RAM.
- Two independent requesters (A, B) compete for the RAM's single write address bus; the block arbitrates round-robin and drives `write[1:0]`, `address`, `data_a`, `data_b` (`write=10` selects port A, `01` selects port B).
- Also sequences a clear-on-reset and clear-on-command pass that zeroes every location.
- Read ports bypass this block.

---
 rtl/dpram_wr_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/dpram_wr_arbiter.sv
// Write-side controller for the shared dual-port RAM: round-robin arbitration between two
// requesters plus a clear pass that zeroes every location after reset or on command.
module dpram_wr_arbiter #(
    parameter int unsigned DW = 4,
    parameter int unsigned AW = 2,
    parameter int unsigned CW = 8
) (
    input  logic          clck,
    input  logic          rst,
    input  logic          clr,
    input  logic          req_a,
    input  logic [AW-1:0] addr_a,
    input  logic [DW-1:0] wdata_a,
    output logic          ack_a,
    input  logic          req_b,
    input  logic [AW-1:0] addr_b,
    input  logic [DW-1:0] wdata_b,
    output logic          ack_b,
    output logic [1:0]    write,
    output logic [AW-1:0] address,
    output logic [DW-1:0] data_a,
    output logic [DW-1:0] data_b,
    output logic          init_busy,
    output logic [CW-1:0] conflict_cnt
);

    localparam int unsigned DEPTH = 2 ** AW;

    typedef enum logic [0:0] {StInit, StIdle} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] init_cnt_q, init_cnt_d;
    logic [1:0]    write_q, write_d;
    logic [AW-1:0] address_q, address_d;
    logic [DW-1:0] data_a_q, data_a_d;
    logic [DW-1:0] data_b_q, data_b_d;
    logic          ack_a_q, ack_a_d;
    logic          ack_b_q, ack_b_d;
    logic          init_busy_q, init_busy_d;
    logic [CW-1:0] conflict_q, conflict_d;
    logic          last_a_q, last_a_d;
    logic          elig_a, elig_b;
    logic          grant_a, grant_b;

    // A requester whose ack is still showing has not had a chance to drop its request yet.
    assign elig_a = req_a & ~ack_a_q;
    assign elig_b = req_b & ~ack_b_q;

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        write_d    = 2'b00;
        address_d  = address_q;
        data_a_d   = data_a_q;
        data_b_d   = data_b_q;
        ack_a_d    = 1'b0;
        ack_b_d    = 1'b0;
        conflict_d = conflict_q;
        last_a_d   = last_a_q;
        grant_a    = 1'b0;
        grant_b    = 1'b0;

        unique case (state_q)
            StInit: begin
                write_d    = 2'b10;
                address_d  = init_cnt_q;
                data_a_d   = '0;
                data_b_d   = '0;
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == AW'(DEPTH - 1)) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                if (clr) begin
                    state_d    = StInit;
                    init_cnt_d = '0;
                end else begin
                    if (elig_a && elig_b) begin
                        grant_a = ~last_a_q;
                        grant_b = last_a_q;
                        if (conflict_q != '1) begin
                            conflict_d = conflict_q + 1'b1;
                        end
                    end else begin
                        grant_a = elig_a;
                        grant_b = elig_b;
                    end

                    if (grant_a) begin
                        write_d   = 2'b10;
                        address_d = addr_a;
                        data_a_d  = wdata_a;
                        ack_a_d   = 1'b1;
                        last_a_d  = 1'b1;
                    end else if (grant_b) begin
                        write_d   = 2'b01;
                        address_d = addr_b;
                        data_b_d  = wdata_b;
                        ack_b_d   = 1'b1;
                        last_a_d  = 1'b0;
                    end
                end
            end
        endcase

        // Busy covers the clr edge and every clear write, dropping once the last write retires.
        init_busy_d = (state_q == StInit) || (state_d == StInit);
    end

    always_ff @(posedge clck or posedge rst) begin
        if (rst) begin
            state_q     <= StInit;
            init_cnt_q  <= '0;
            write_q     <= 2'b00;
            address_q   <= '0;
            data_a_q    <= '0;
            data_b_q    <= '0;
            ack_a_q     <= 1'b0;
            ack_b_q     <= 1'b0;
            init_busy_q <= 1'b1;
            conflict_q  <= '0;
            last_a_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            write_q     <= write_d;
            address_q   <= address_d;
            data_a_q    <= data_a_d;
            data_b_q    <= data_b_d;
            ack_a_q     <= ack_a_d;
            ack_b_q     <= ack_b_d;
            init_busy_q <= init_busy_d;
            conflict_q  <= conflict_d;
            last_a_q    <= last_a_d;
        end
    end

    assign write        = write_q;
    assign address      = address_q;
    assign data_a       = data_a_q;
    assign data_b       = data_b_q;
    assign ack_a        = ack_a_q;
    assign ack_b        = ack_b_q;
    assign init_busy    = init_busy_q;
    assign conflict_cnt = conflict_q;

endmodule
